// File: rtl/insn_fetch_queue.sv
// insn_fetch_queue: sequential instruction fetch with a DEPTH-entry prefetch
// queue. The queue head goes either to decode or to the co-processor port,
// and the fetch stream is flushed and re-steered on a PC change request.
// At most one memory request is outstanding at any time.
// Optional build macro FETCH_PERF_CNT_EN adds stall/flush performance counters.
module insn_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [6:0]  CP_OPCODE = 7'h7F
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    output logic [31:0]             insn_mem_addr_out,
    output logic                    insn_mem_read_out,
    input  logic                    insn_mem_stall_in,
    input  logic                    insn_mem_ack_in,
    input  logic [31:0]             insn_mem_in,
    input  logic                    pc_change_req_in,
    input  logic [31:0]             pc_change_addr_in,
    output logic [31:0]             insn_out,
    output logic [31:0]             insn_pc_out,
    output logic                    insn_valid_out,
    input  logic                    insn_ready_in,
    output logic [31:0]             cpinsn_out,
    output logic [31:0]             cpinsn_pc_out,
    output logic                    cpinsn_valid_out,
    input  logic                    cpinsn_ready_in,
    output logic [$clog2(DEPTH):0]  count_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cycles_out,
    output logic [31:0]             flush_count_out
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic [31:0]   insn_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic [31:0]   head_insn, head_pc;
    logic          not_empty, head_is_cp;
    logic          main_valid, cp_valid, deq, enq;
    logic          req_accept, ack_in_wait;
    logic [CW-1:0] count_after_deq, count_after;

    // Head decode, dequeue/enqueue qualifiers and occupancy bookkeeping
    always_comb begin
        head_insn       = insn_q[rd_ptr_reg];
        head_pc         = pc_q[rd_ptr_reg];
        not_empty       = (count_reg != '0);
        head_is_cp      = (head_insn[6:0] == CP_OPCODE);
        main_valid      = not_empty && !head_is_cp;
        cp_valid        = not_empty && head_is_cp;
        // Only the port the head is routed to can consume it
        deq             = (main_valid && insn_ready_in) || (cp_valid && cpinsn_ready_in);
        req_accept      = (state_reg == ST_REQ) && !insn_mem_stall_in;
        ack_in_wait     = (state_reg == ST_WAIT) && insn_mem_ack_in;
        enq             = ack_in_wait && !pc_change_req_in;
        count_after_deq = count_reg - CW'(deq);
        count_after     = count_after_deq + CW'(enq);
    end

    // Fetch FSM next state and next fetch address; redirect overrides everything
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (pc_change_req_in) begin
            fetch_pc_next = pc_change_addr_in & ~32'h3;
            // A request the memory has taken (or is taking now) still owes
            // an ack, which must be swallowed before the new stream starts
            if ((state_reg == ST_WAIT && !insn_mem_ack_in) || req_accept)
                state_next = ST_DROP;
            else if (state_reg == ST_DROP && !insn_mem_ack_in)
                state_next = ST_DROP;
            else
                state_next = ST_REQ;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (count_after_deq < CW'(DEPTH))
                        state_next = ST_REQ;
                end
                ST_REQ: begin
                    if (!insn_mem_stall_in)
                        state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (insn_mem_ack_in) begin
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                        state_next    = (count_after < CW'(DEPTH)) ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (insn_mem_ack_in)
                        state_next = ST_REQ;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM, fetch PC, queue pointers and occupancy registers
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            if (pc_change_req_in) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (enq)
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (deq)
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                count_reg <= count_after;
            end
        end
    end

    // Queue storage: instruction word and its PC, written on enqueue only
    always_ff @(posedge clk_in) begin
        if (enq) begin
            insn_q[wr_ptr_reg] <= insn_mem_in;
            pc_q[wr_ptr_reg]   <= fetch_pc_reg;
        end
    end

    // Output drive from registered state; data ports read as zero when idle
    always_comb begin
        insn_mem_read_out = (state_reg == ST_REQ);
        insn_mem_addr_out = insn_mem_read_out ? fetch_pc_reg : 32'h0;
        insn_valid_out    = main_valid;
        insn_out          = main_valid ? head_insn : 32'h0;
        insn_pc_out       = main_valid ? head_pc : 32'h0;
        cpinsn_valid_out  = cp_valid;
        cpinsn_out        = cp_valid ? head_insn : 32'h0;
        cpinsn_pc_out     = cp_valid ? head_pc : 32'h0;
        count_out         = count_reg;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_count_reg;
    logic        stall_event;

    assign stall_event = ((state_reg == ST_REQ) && insn_mem_stall_in) ||
                         ((state_reg == ST_WAIT) && !insn_mem_ack_in);

    // Saturating stall-cycle and flush counters
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (stall_event && (stall_cycles_reg != 32'hFFFF_FFFF))
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            if (pc_change_req_in && (flush_count_reg != 32'hFFFF_FFFF))
                flush_count_reg <= flush_count_reg + 32'd1;
        end
    end

    assign stall_cycles_out = stall_cycles_reg;
    assign flush_count_out  = flush_count_reg;
`endif

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Directed testbench for insn_fetch_queue (DEPTH=4, RESET_PC=0, CP_OPCODE=7F).
// A small instruction-memory responder runs once per cycle inside the stimulus
// process; requests and deliveries are logged one line each.
module tb_insn_fetch_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_stall;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        pc_change;
    logic [31:0] pc_change_addr;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] cpinsn;
    logic [31:0] cpinsn_pc;
    logic        cpinsn_valid;
    logic        cp_ready;
    logic [2:0]  count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;

    // memory responder state
    bit          pend_valid;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          ack_delay;
    bit          late_ack;
    bit          cp_en;
    logic [31:0] cp_addr;

    logic [31:0] issued[$];
    logic [31:0] deliv_pc[$];
    logic [31:0] deliv_insn[$];
    bit          deliv_cp[$];

    always #5 clk = ~clk;

    insn_fetch_queue #(
        .DEPTH(4),
        .RESET_PC(32'h0000_0000),
        .CP_OPCODE(7'h7F)
    ) dut (
        .clk_in(clk),
        .reset_n_in(reset_n),
        .insn_mem_addr_out(mem_addr),
        .insn_mem_read_out(mem_read),
        .insn_mem_stall_in(mem_stall),
        .insn_mem_ack_in(mem_ack),
        .insn_mem_in(mem_data),
        .pc_change_req_in(pc_change),
        .pc_change_addr_in(pc_change_addr),
        .insn_out(insn),
        .insn_pc_out(insn_pc),
        .insn_valid_out(insn_valid),
        .insn_ready_in(insn_ready),
        .cpinsn_out(cpinsn),
        .cpinsn_pc_out(cpinsn_pc),
        .cpinsn_valid_out(cpinsn_valid),
        .cpinsn_ready_in(cp_ready),
        .count_out(count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles_out(stall_cycles),
        .flush_count_out(flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents: address-derived words whose low 7 bits are never 7F,
    // except one optional co-processor word
    function automatic logic [31:0] gen(input logic [31:0] a);
        if (cp_en && a == cp_addr)
            return 32'hABCD_007F;
        return a ^ 32'h1357_0000;
    endfunction

    function automatic logic [31:0] issued_at(input int i);
        if (i < issued.size()) return issued[i];
        return 32'hBAD0_0BAD;
    endfunction

    function automatic logic [31:0] dpc_at(input int i);
        if (i < deliv_pc.size()) return deliv_pc[i];
        return 32'hBAD0_0BAD;
    endfunction

    function automatic logic [31:0] dinsn_at(input int i);
        if (i < deliv_insn.size()) return deliv_insn[i];
        return 32'hBAD0_0BAD;
    endfunction

    function automatic logic [31:0] dcp_at(input int i);
        if (i < deliv_cp.size()) return 32'(deliv_cp[i]);
        return 32'hBAD0_0BAD;
    endfunction

    // Called at a negedge: drive memory inputs for the coming edge, log the
    // handshakes that edge will complete, then advance to the next negedge.
    task automatic cycle();
        mem_ack  = 1'b0;
        mem_data = 32'h0;
        if (late_ack) begin
            mem_ack  = 1'b1;
            mem_data = 32'hDEAD_BEEF;
            late_ack = 1'b0;
        end else if (pend_valid) begin
            if (pend_wait == 0) begin
                mem_ack    = 1'b1;
                mem_data   = gen(pend_addr);
                pend_valid = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        if (mem_read && !mem_stall) begin
            pend_valid = 1'b1;
            pend_addr  = mem_addr;
            pend_wait  = ack_delay;
            issued.push_back(mem_addr);
            $display("req     addr=%h", mem_addr);
        end
        if (insn_valid && insn_ready) begin
            deliv_pc.push_back(insn_pc);
            deliv_insn.push_back(insn);
            deliv_cp.push_back(1'b0);
            $display("deliver main pc=%h insn=%h", insn_pc, insn);
        end
        if (cpinsn_valid && cp_ready) begin
            deliv_pc.push_back(cpinsn_pc);
            deliv_insn.push_back(cpinsn);
            deliv_cp.push_back(1'b1);
            $display("deliver cp   pc=%h insn=%h", cpinsn_pc, cpinsn);
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        issued.delete();
        deliv_pc.delete();
        deliv_insn.delete();
        deliv_cp.delete();
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        pend_valid     = 1'b0;
        late_ack       = 1'b0;
        mem_ack        = 1'b0;
        mem_data       = 32'h0;
        mem_stall      = 1'b0;
        pc_change      = 1'b0;
        pc_change_addr = 32'h0;
        ack_delay      = 0;
        repeat (2) @(negedge clk);
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cp_en      = 1'b0;
        cp_addr    = 32'h0;
        insn_ready = 1'b1;
        cp_ready   = 1'b1;
        apply_reset();

        // ---- reset state ----
        check("rst_read", 32'(mem_read), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_valid", 32'(insn_valid), 32'd0);
        check("rst_cpvalid", 32'(cpinsn_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_insn", insn, 32'h0);
        check("rst_pc", insn_pc, 32'h0);
        check("rst_cpinsn", cpinsn, 32'h0);

        // ---- streaming fetch, first valid 3 cycles after release ----
        reset_n = 1'b1;
        cycle();
        check("t1_valid_c1", 32'(insn_valid), 32'd0);
        check("t1_read_c1", 32'(mem_read), 32'd1);
        cycle();
        check("t1_valid_c2", 32'(insn_valid), 32'd0);
        cycle();
        check("t1_valid_c3", 32'(insn_valid), 32'd1);
        check("t1_pc_c3", insn_pc, 32'h0);
        check("t1_insn_c3", insn, 32'h1357_0000);
        repeat (10) cycle();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_issued%0d", i), issued_at(i), 32'(i * 4));
            check($sformatf("t1_pc%0d", i), dpc_at(i), 32'(i * 4));
        end
        check("t1_insn1", dinsn_at(1), 32'h1357_0004);

        // ---- decode stalled: queue fills to DEPTH, fetch stops ----
        insn_ready = 1'b0;
        apply_reset();
        reset_n = 1'b1;
        repeat (20) cycle();
        check("t2_nreq", 32'(issued.size()), 32'd4);
        check("t2_last_addr", issued_at(3), 32'h0000_000C);
        check("t2_count", 32'(count), 32'd4);
        check("t2_read_held", 32'(mem_read), 32'd0);
        check("t2_valid", 32'(insn_valid), 32'd1);
        insn_ready = 1'b1;
        cycle();
        check("t2_read_resume", 32'(mem_read), 32'd1);
        check("t2_addr_resume", mem_addr, 32'h0000_0010);
        check("t2_count_after", 32'(count), 32'd3);

        // ---- redirect while waiting for a slow ack ----
        apply_reset();
        ack_delay = 1;
        reset_n = 1'b1;
        cycle();
        cycle();
        check("t3_in_wait", 32'(mem_read), 32'd0);
        pc_change      = 1'b1;
        pc_change_addr = 32'h0000_1003;
        cycle();
        pc_change = 1'b0;
        ack_delay = 0;
        check("t3_valid", 32'(insn_valid), 32'd0);
        check("t3_cpvalid", 32'(cpinsn_valid), 32'd0);
        check("t3_read_drop", 32'(mem_read), 32'd0);
        cycle();
        check("t3_read", 32'(mem_read), 32'd1);
        check("t3_addr", mem_addr, 32'h0000_1000);
        check("t3_count", 32'(count), 32'd0);
        mem_stall = 1'b1;
        cycle();
        mem_stall = 1'b0;
        check("t3_stall_read", 32'(mem_read), 32'd1);
        check("t3_stall_addr", mem_addr, 32'h0000_1000);
        repeat (6) cycle();
        check("t3_first_pc", dpc_at(0), 32'h0000_1000);
        check("t3_first_insn", dinsn_at(0), 32'h1357_1000);

        // ---- co-processor head blocks program order ----
        apply_reset();
        cp_en    = 1'b1;
        cp_addr  = 32'h0;
        cp_ready = 1'b0;
        reset_n  = 1'b1;
        repeat (3) cycle();
        check("t4_cpvalid", 32'(cpinsn_valid), 32'd1);
        check("t4_valid", 32'(insn_valid), 32'd0);
        check("t4_cpinsn", cpinsn, 32'hABCD_007F);
        check("t4_cppc", cpinsn_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("t4_hold_cp%0d", i), 32'(cpinsn_valid), 32'd1);
            check($sformatf("t4_hold_main%0d", i), 32'(insn_valid), 32'd0);
        end
        check("t4_none_main", 32'(deliv_pc.size()), 32'd0);
        cp_ready = 1'b1;
        cycle();
        check("t4_after_cpvalid", 32'(cpinsn_valid), 32'd0);
        check("t4_after_valid", 32'(insn_valid), 32'd1);
        check("t4_after_pc", insn_pc, 32'h0000_0004);
        cycle();
        check("t4_order0_port", dcp_at(0), 32'd1);
        check("t4_order1_port", dcp_at(1), 32'd0);
        check("t4_order1_pc", dpc_at(1), 32'h0000_0004);
        cp_en = 1'b0;

        // ---- flush a full queue and redirect to the top of memory ----
        insn_ready = 1'b0;
        apply_reset();
        reset_n = 1'b1;
        repeat (12) cycle();
        check("t5_full", 32'(count), 32'd4);
        pc_change      = 1'b1;
        pc_change_addr = 32'hFFFF_FFFC;
        cycle();
        pc_change = 1'b0;
        check("t5_flushed", 32'(count), 32'd0);
        check("t5_valid", 32'(insn_valid), 32'd0);
        check("t5_read", 32'(mem_read), 32'd1);
        check("t5_addr", mem_addr, 32'hFFFF_FFFC);
        clear_logs();
        insn_ready = 1'b1;
        repeat (10) cycle();
        check("t5_issued0", issued_at(0), 32'hFFFF_FFFC);
        check("t5_issued1", issued_at(1), 32'h0000_0000);
        check("t5_pc0", dpc_at(0), 32'hFFFF_FFFC);
        check("t5_pc1", dpc_at(1), 32'h0000_0000);
        check("t5_insn1", dinsn_at(1), 32'h1357_0000);

        // ---- asynchronous reset in the middle of a wait ----
        insn_ready = 1'b0;
        apply_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 12 && !(count >= 3'd2 && mem_read); i++) cycle();
        check("t6_pre_count", 32'(count), 32'd2);
        check("t6_pre_read", 32'(mem_read), 32'd1);
        ack_delay = 3;
        cycle();
        check("t6_in_wait", 32'(mem_read), 32'd0);
        check("t6_pre_valid", 32'(insn_valid), 32'd1);
        #2;
        reset_n    = 1'b0;
        pend_valid = 1'b0;
        ack_delay  = 0;
        #1;
        check("t6_rst_read", 32'(mem_read), 32'd0);
        check("t6_rst_addr", mem_addr, 32'h0);
        check("t6_rst_valid", 32'(insn_valid), 32'd0);
        check("t6_rst_cpvalid", 32'(cpinsn_valid), 32'd0);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_pc", insn_pc, 32'h0);
        @(negedge clk);
        reset_n  = 1'b1;
        late_ack = 1'b1;
        clear_logs();
        cycle();
        check("t6_restart_count", 32'(count), 32'd0);
        check("t6_restart_read", 32'(mem_read), 32'd1);
        check("t6_restart_addr", mem_addr, 32'h0);
        insn_ready = 1'b1;
        repeat (8) cycle();
        check("t6_first_pc", dpc_at(0), 32'h0);
        check("t6_first_insn", dinsn_at(0), 32'h1357_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
